alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge), reset.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  instruction accepted when high with instr_valid.
REQ-006 instr  input  10  {op[3:0], rd[2:0], rs[2:0]}; op uses the 4-bit ALU opcode map (0000 ADD … 1110 MULTIPLY, 1111 COMPARE).
REQ-007 wr_en / wr_addr / wr_data  input  1/3/8  host register-file load port.
REQ-008 dbg_addr  input  3;  dbg_data  output  8  combinational read of R[dbg_addr].
REQ-009 alu_A, alu_B  output  8 each;  alu_fsl  output  4  operands and opcode driven to the ALU.
REQ-010 alu_result, alu_mul_high  input  8 each;  alu_sreg  input  4 {V,S,C,Z}  combinational ALU outputs.
REQ-011 status  output  4  registered {V,S,C,Z}.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse when an instruction retires.

Function
REQ-014 Register file SHALL be 8 x 8-bit, R0..R7, two-address: A = R[rd], B = R[rs], result -> R[rd].
REQ-015 FSM states SHALL be IDLE, EXEC, WB, WBH (WBH exists only per REQ-028).
REQ-016 instr_ready SHALL equal (state==IDLE) & ~wr_en; host write wins a same-cycle conflict, instruction stays pending.
REQ-017 Host write SHALL update R[wr_addr] at the edge only when state==IDLE; wr_en in any other state is ignored (dropped, no queueing).
REQ-018 On acceptance, op/rd/rs SHALL be latched and state IDLE->EXEC.
REQ-019 In EXEC, alu_A=R[rd], alu_B=R[rs], alu_fsl=latched op; at end of EXEC alu_result, alu_mul_high, alu_sreg SHALL be captured into holding registers; EXEC->WB.
REQ-020 Outside EXEC, alu_A, alu_B SHALL be 0 and alu_fsl SHALL be 4'b1111 (COMPARE, no side effects).
REQ-021 In WB: status <= captured sreg; R[rd] <= captured result unless op==COMPARE (no register write); done=1; WB->IDLE (or WBH per REQ-028).
REQ-022 Latency: instruction accepted at edge n -> done high in cycle n+2, R[rd]/status updated at edge n+3; back-to-back issue SHALL allow one instruction per 3 cycles (4 for MULTIPLY with REQ-028).
REQ-023 rd==rs SHALL be legal: both operands read the same pre-instruction value.
REQ-024 dbg_data SHALL reflect the register file, not in-flight holding values; it updates the cycle after a write edge.
REQ-025 status SHALL change only in WB; COMPARE updates status (Z = compare outcome).

Reset
REQ-026 reset SHALL force: state IDLE, R0..R7=0, status=0, holding registers=0, done=0, busy=0, alu_A=alu_B=0, alu_fsl=4'b1111; instr_ready=1 the first cycle after reset deasserts.
REQ-027 reset in EXEC/WB/WBH SHALL abort the instruction: no register or status write, no done pulse.

Configuration
REQ-028 Macro ALU_SEQ_MULHI_EN: defined -> MULTIPLY goes WB->WBH, writing R[(rd+1) mod 8] <= captured mul_high in WBH (rd=7 wraps to R0), done pulses in WBH, not WB; undefined -> no WBH, mul_high discarded, MULTIPLY retires like ADD.

Verification
REQ-029 Load R1=0x7F, R2=0x01; ADD rd=1,rs=2 -> R1=0x80, status V=1,S=1,C=0,Z=0; done in cycle n+2.
REQ-030 Load R3=0x05; SUB rd=3,rs=3 -> R3=0x00, status Z=1.
REQ-031 With ALU_SEQ_MULHI_EN: R7=0x10, R0=0x20, MULTIPLY rd=7,rs=0 -> R7=0x00, R0=0x02 (wrap), done only in WBH; without macro R0 unchanged.
REQ-032 COMPARE rd=4,rs=5 with R4=R5=0x33 -> status Z per ALU compare output, R4 still 0x33.
REQ-033 wr_en asserted with instr_valid in IDLE -> write lands, instr_ready=0 that cycle, instruction accepted next cycle; wr_en during EXEC -> no change to R.
REQ-034 Assert reset in EXEC of ADD rd=1 -> R1=0, status=0, no done, state IDLE next cycle.

Source files
------------

// File: rtl/alu_sequencer.sv
// Two-address instruction sequencer driving an external 8-bit ALU over an 8x8 register file.
// Optional macro ALU_SEQ_MULHI_EN: MULTIPLY also writes mul_high into R[(rd+1) mod 8] in an extra WBH state.
`timescale 1ns/1ps
module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [9:0] instr,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic [7:0] alu_A,
  output logic [7:0] alu_B,
  output logic [3:0] alu_fsl,
  input  logic [7:0] alu_result,
  input  logic [7:0] alu_mul_high,
  input  logic [3:0] alu_sreg,
  output logic [3:0] status,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] OP_MUL = 4'b1110;
  localparam logic [3:0] OP_CMP = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, WB, WBH} state_e;

  state_e     state_q;
  logic [7:0] regs_q [8];
  logic [3:0] op_q;
  logic [2:0] rd_q;
  logic [7:0] res_q;
  logic [3:0] sreg_q;
  logic [3:0] status_q;
  logic       done_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [3:0] alu_fsl_q;

  logic       wbh_d;
  logic [2:0] rd_hi_d;

`ifdef ALU_SEQ_MULHI_EN
  logic [7:0] mulh_q;
`else
  logic       unused_mulh;
  assign unused_mulh = ^alu_mul_high;
`endif

  always_comb begin
    rd_hi_d = rd_q + 3'd1;
`ifdef ALU_SEQ_MULHI_EN
    wbh_d   = (op_q == OP_MUL);
`else
    wbh_d   = 1'b0;
`endif
  end

  assign instr_ready = (state_q == IDLE) & ~wr_en;
  assign busy        = (state_q != IDLE);
  assign dbg_data    = regs_q[dbg_addr];
  assign status      = status_q;
  assign done        = done_q;
  assign alu_A       = alu_a_q;
  assign alu_B       = alu_b_q;
  assign alu_fsl     = alu_fsl_q;

  // Operands are sampled from the register file at acceptance, so rd==rs
  // naturally sees the same pre-instruction value on both ALU inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      sreg_q    <= '0;
      status_q  <= '0;
      done_q    <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fsl_q <= OP_CMP;
`ifdef ALU_SEQ_MULHI_EN
      mulh_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
          end else if (instr_valid) begin
            op_q      <= instr[9:6];
            rd_q      <= instr[5:3];
            alu_a_q   <= regs_q[instr[5:3]];
            alu_b_q   <= regs_q[instr[2:0]];
            alu_fsl_q <= instr[9:6];
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          res_q     <= alu_result;
          sreg_q    <= alu_sreg;
`ifdef ALU_SEQ_MULHI_EN
          mulh_q    <= alu_mul_high;
`endif
          alu_a_q   <= '0;
          alu_b_q   <= '0;
          alu_fsl_q <= OP_CMP;
          // done is registered, so it is raised here to be visible during WB
          done_q    <= ~wbh_d;
          state_q   <= WB;
        end
        WB: begin
          status_q <= sreg_q;
          if (op_q != OP_CMP) regs_q[rd_q] <= res_q;
          if (wbh_d) begin
            done_q  <= 1'b1;
            state_q <= WBH;
          end else begin
            state_q <= IDLE;
          end
        end
        WBH: begin
`ifdef ALU_SEQ_MULHI_EN
          regs_q[rd_hi_d] <= mulh_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef ALU_SEQ_MULHI_EN
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_hi_d;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU attached to its ALU port.
`timescale 1ns/1ps
module tb_alu_sequencer;

  localparam logic [3:0] ADD = 4'h0;
  localparam logic [3:0] SUB = 4'h1;
  localparam logic [3:0] MUL = 4'hE;
  localparam logic [3:0] CMP = 4'hF;
`ifdef ALU_SEQ_MULHI_EN
  localparam bit MULHI = 1'b1;
`else
  localparam bit MULHI = 1'b0;
`endif

  logic       clk, reset, instr_valid, instr_ready, wr_en, busy, done;
  logic [9:0] instr;
  logic [2:0] wr_addr, dbg_addr;
  logic [7:0] wr_data, dbg_data, alu_A, alu_B, alu_result, alu_mul_high;
  logic [3:0] alu_fsl, alu_sreg, status;

  int tests = 0;
  int fails = 0;
  int cyc;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .alu_A(alu_A), .alu_B(alu_B),
    .alu_fsl(alu_fsl), .alu_result(alu_result), .alu_mul_high(alu_mul_high),
    .alu_sreg(alu_sreg), .status(status), .busy(busy), .done(done)
  );

  always #50 clk = ~clk;

  // Reference ALU: flags are {V,S,C,Z}; COMPARE behaves as a subtract.
  logic [8:0]  s9;
  logic [15:0] p16;
  always_comb begin
    s9 = '0;
    p16 = '0;
    alu_result = alu_A;
    alu_mul_high = '0;
    alu_sreg = '0;
    case (alu_fsl)
      ADD: begin
        s9 = {1'b0, alu_A} + {1'b0, alu_B};
        alu_result = s9[7:0];
        alu_sreg = {(alu_A[7] == alu_B[7]) && (s9[7] != alu_A[7]), s9[7], s9[8], s9[7:0] == 8'h00};
      end
      SUB, CMP: begin
        s9 = {1'b0, alu_A} - {1'b0, alu_B};
        alu_result = s9[7:0];
        alu_sreg = {(alu_A[7] != alu_B[7]) && (s9[7] != alu_A[7]), s9[7], s9[8], s9[7:0] == 8'h00};
      end
      MUL: begin
        p16 = alu_A * alu_B;
        alu_result = p16[7:0];
        alu_mul_high = p16[15:8];
        alu_sreg = {1'b0, p16[15], p16[15:8] != 8'h00, p16 == 16'h0000};
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input logic [2:0] a, input logic [7:0] e, input string tag);
    dbg_addr = a;
    #1;
    chk(tag, {24'h0, dbg_data}, {24'h0, e});
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Issues one instruction from IDLE and follows it to retirement.
  task automatic run_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [7:0] ea, input logic [7:0] eb, input string tag);
    bit mh;
    mh = MULHI && (op == MUL);
    instr_valid = 1'b1;
    instr = {op, rd, rs};
    #1 chk({tag, ".ready"}, {31'h0, instr_ready}, 32'h1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, ".exec_busy"}, {31'h0, busy}, 32'h1);
    chk({tag, ".alu_A"}, {24'h0, alu_A}, {24'h0, ea});
    chk({tag, ".alu_B"}, {24'h0, alu_B}, {24'h0, eb});
    chk({tag, ".alu_fsl"}, {28'h0, alu_fsl}, {28'h0, op});
    @(negedge clk);
    chk({tag, ".done_wb"}, {31'h0, done}, {31'h0, !mh});
    chk({tag, ".fsl_idle"}, {28'h0, alu_fsl}, 32'hF);
    if (mh) begin
      @(negedge clk);
      chk({tag, ".done_wbh"}, {31'h0, done}, 32'h1);
    end
    @(negedge clk);
    chk({tag, ".done_clr"}, {31'h0, done}, 32'h0);
    chk({tag, ".idle"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; reset = 1'b1; instr_valid = 1'b0; instr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("rst.ready", {31'h0, instr_ready}, 32'h1);
    @(negedge clk);
    chk("rst.busy", {31'h0, busy}, 32'h0);
    chk("rst.done", {31'h0, done}, 32'h0);
    chk("rst.status", {28'h0, status}, 32'h0);
    chk("rst.alu_A", {24'h0, alu_A}, 32'h0);
    chk("rst.alu_B", {24'h0, alu_B}, 32'h0);
    chk("rst.alu_fsl", {28'h0, alu_fsl}, 32'hF);
    for (int i = 0; i < 8; i++) chk_reg(3'(i), 8'h00, "rst.reg");

    // ADD overflow into sign bit
    @(negedge clk);
    host_write(3'd1, 8'h7F);
    host_write(3'd2, 8'h01);
    chk_reg(3'd1, 8'h7F, "load.R1");
    run_instr(ADD, 3'd1, 3'd2, 8'h7F, 8'h01, "add");
    chk_reg(3'd1, 8'h80, "add.R1");
    chk("add.status", {28'h0, status}, 32'hC);

    // rd==rs subtract
    host_write(3'd3, 8'h05);
    run_instr(SUB, 3'd3, 3'd3, 8'h05, 8'h05, "sub");
    chk_reg(3'd3, 8'h00, "sub.R3");
    chk("sub.status", {28'h0, status}, 32'h1);

    // MULTIPLY with rd=7 so the high byte wraps to R0 when enabled
    host_write(3'd7, 8'h10);
    host_write(3'd0, 8'h20);
    run_instr(MUL, 3'd7, 3'd0, 8'h10, 8'h20, "mul");
    chk_reg(3'd7, 8'h00, "mul.R7");
    chk_reg(3'd0, MULHI ? 8'h02 : 8'h20, "mul.R0");
    chk("mul.status", {28'h0, status}, 32'h2);

    // COMPARE: status updates, no register write
    host_write(3'd4, 8'h33);
    host_write(3'd5, 8'h33);
    run_instr(CMP, 3'd4, 3'd5, 8'h33, 8'h33, "cmp");
    chk_reg(3'd4, 8'h33, "cmp.R4");
    chk("cmp.status", {28'h0, status}, 32'h1);

    // Host write colliding with instruction offer, then write during EXEC
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'hA5;
    instr_valid = 1'b1; instr = {ADD, 3'd6, 3'd2};
    #1 chk("coll.ready_low", {31'h0, instr_ready}, 32'h0);
    @(negedge clk);
    wr_en = 1'b0;
    chk_reg(3'd6, 8'hA5, "coll.R6_written");
    chk("coll.ready_high", {31'h0, instr_ready}, 32'h1);
    chk("coll.not_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("coll.exec_busy", {31'h0, busy}, 32'h1);
    chk("coll.alu_A", {24'h0, alu_A}, 32'hA5);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h00;
    @(negedge clk);
    wr_en = 1'b0;
    chk("coll.done", {31'h0, done}, 32'h1);
    @(negedge clk);
    chk_reg(3'd6, 8'hA6, "coll.R6_result");
    chk("coll.status", {28'h0, status}, 32'h4);

    // Reset during EXEC aborts the instruction
    instr_valid = 1'b1; instr = {ADD, 3'd1, 3'd2};
    @(negedge clk);
    instr_valid = 1'b0;
    chk("abort.in_exec", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort.busy", {31'h0, busy}, 32'h0);
    chk("abort.done", {31'h0, done}, 32'h0);
    chk("abort.status", {28'h0, status}, 32'h0);
    chk("abort.alu_fsl", {28'h0, alu_fsl}, 32'hF);
    chk_reg(3'd1, 8'h00, "abort.R1");
    @(negedge clk);
    chk("abort.no_done", {31'h0, done}, 32'h0);

    // Back-to-back issue with instr_valid held high
    host_write(3'd2, 8'h03);
    instr_valid = 1'b1; instr = {ADD, 3'd2, 3'd2};
    wait_done(cyc);
    chk("b2b.first_latency", cyc, 2);
    wait_done(cyc);
    instr_valid = 1'b0;
    chk("b2b.interval", cyc, 3);
    @(negedge clk);
    chk_reg(3'd2, 8'h0C, "b2b.R2");
    @(negedge clk);
    chk("b2b.idle", {31'h0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
